// File: rtl/serial_sub_pkg.sv
// Shared state encoding and overflow helper for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed overflow of a-b: operands differ in sign and the result sign differs from a.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: the per-bit datapath of the serial subtractor.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per RUN cycle; results held from DONE entry.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;

    logic fs_diff;
    logic fs_bout;

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (bin_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    bin_d   = 1'b0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                end
            end
            RUN: begin
                a_sh_d       = a_sh_q >> 1;
                b_sh_d       = b_sh_q >> 1;
                bin_d        = fs_bout;
                res_d[cnt_q] = fs_diff;
                cnt_d        = cnt_q + CW'(1);
                // Last bit: publish the completed word together with the final borrow.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d    = DONE;
                    diff_d     = res_d;
                    borrow_d   = fs_bout;
                    overflow_d = sub_overflow(a_msb_q, b_msb_q, res_d[WIDTH-1]);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            bin_q      <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with an 8-bit and a 1-bit instance.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start1;
    logic [7:0] a, b;
    logic [0:0] a1, b1;
    logic       ready, busy, done, borrow, overflow;
    logic [7:0] diff;
    logic       ready1, busy1, done1, borrow1, overflow1;
    logic [0:0] diff1;

    int total = 0;
    int bad   = 0;
    bit onehot_en = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .diff(diff),
        .borrow(borrow), .overflow(overflow)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .ready(ready1), .busy(busy1), .done(done1), .diff(diff1),
        .borrow(borrow1), .overflow(overflow1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (onehot_en) begin
            check("onehot8", 32'($countones({ready, busy, done})), 32'd1);
            check("onehot1", 32'($countones({ready1, busy1, done1})), 32'd1);
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 20) begin
            tick();
            if (!done) n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow), 32'(eb));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
        tick();
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_hold"}, 32'(diff), 32'(ed));
    endtask

    task automatic run_op1(input string tag, input logic av, input logic bv,
                           input logic ed, input logic eb, input logic eo);
        a1 = av; b1 = bv; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check({tag, "_busy"}, 32'(busy1), 32'd1);
        tick();
        check({tag, "_done"}, 32'(done1), 32'd1);
        check({tag, "_diff"}, 32'(diff1), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow1), 32'(eb));
        check({tag, "_ovf"}, 32'(overflow1), 32'(eo));
        tick();
        check({tag, "_ready"}, 32'(ready1), 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
        a = '0; b = '0; a1 = '0; b1 = '0;
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_ready1", 32'(ready1), 32'd1);
        rst_n = 1'b1;
        onehot_en = 1'b1;
        tick();

        run_op("5m3", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("3m5", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("7Fm FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run_op("FFmFF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

        // start held high, operands scrambled during RUN
        a = 8'h20; b = 8'h0A; start = 1'b1;
        tick();
        check("hold_busy", 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 20) begin
            a = 8'($urandom); b = 8'($urandom);
            tick();
            if (!done) begin
                n++;
                check("hold_noready", 32'(ready), 32'd0);
            end
        end
        check("hold_latency", 32'(n), 32'd8);
        check("hold_diff", 32'(diff), 32'h16);
        check("hold_borrow", 32'(borrow), 32'd0);
        tick();
        check("hold_ready_gap", 32'(ready), 32'd1);
        a = 8'h09; b = 8'h04;
        tick();
        check("hold_second_busy", 32'(busy), 32'd1);
        check("hold_second_noready", 32'(ready), 32'd0);
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            tick();
            if (!done) n++;
        end
        check("hold2_latency", 32'(n), 32'd8);
        check("hold2_diff", 32'(diff), 32'h05);
        tick();

        // abort at the 4th RUN edge
        a = 8'h33; b = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy0", 32'(busy), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_nodone", 32'(done), 32'd0);
        end
        run_op("10m01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        // reset wins over a simultaneous start
        a = 8'h44; b = 8'h22; start = 1'b1; rst_n = 1'b0;
        tick();
        check("rstprio_ready", 32'(ready), 32'd1);
        check("rstprio_busy", 32'(busy), 32'd0);
        start = 1'b0; rst_n = 1'b1;
        tick();

        run_op1("w1_0m1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        run_op1("w1_1m1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op1("w1_1m0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
